// File: rtl/multi_register_bank_pkg.sv
// rtl/multi_register_bank_pkg.sv - shared op encodings for the multi-register bank
package multi_register_bank_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_INC    = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

endpackage

// File: rtl/multi_register_bank_read_port.sv
// rtl/multi_register_bank_read_port.sv - combinational read mux with active-low select
module bank_read_port #(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 4,
    parameter int AddrBits = 2
) (
    input  logic [NrOfRegs*NrOfBits-1:0] bank,
    input  logic [AddrBits-1:0]          RdAddr,
    input  logic                         cs,
    output logic [NrOfBits-1:0]          Q
);

    // Out-of-range addresses and a deselected port both fall through to zero.
    always_comb begin
        Q = '0;
        if (!cs) begin
            for (int i = 0; i < NrOfRegs; i++) begin
                if (32'(RdAddr) == i)
                    Q = bank[i*NrOfBits +: NrOfBits];
            end
        end
    end

endmodule

// File: rtl/multi_register_bank.sv
// rtl/multi_register_bank.sv - register bank with LOAD/INC/PRESET/CLEAR writes and two read ports
module multi_register_bank
    import multi_register_bank_pkg::*;
#(
    parameter int                  NrOfBits    = 8,
    parameter int                  NrOfRegs    = 4,
    parameter int                  AddrBits    = 2,
    parameter logic [NrOfBits-1:0] PresetValue = '1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                WrEn,
    input  logic [AddrBits-1:0] WrAddr,
    input  logic [1:0]          Op,
    input  logic [NrOfBits-1:0] D,
    input  logic [AddrBits-1:0] RdAddrA,
    input  logic [AddrBits-1:0] RdAddrB,
    input  logic                csA,
    input  logic                csB,
    output logic [NrOfBits-1:0] QA,
    output logic [NrOfBits-1:0] QB,
    output logic                Carry,
    output logic                WrAck
);

    logic [NrOfBits-1:0]          regs [NrOfRegs];
    logic [NrOfRegs*NrOfBits-1:0] bank_flat;
    logic                         commit;

    assign commit = WrEn & ClockEnable & Tick & (32'(WrAddr) < NrOfRegs);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NrOfRegs; i++)
                regs[i] <= '0;
            Carry <= 1'b0;
            WrAck <= 1'b0;
        end else begin
            WrAck <= commit;
            if (commit) begin
                case (Op)
                    OP_LOAD:   regs[WrAddr] <= D;
                    OP_INC: begin
                        regs[WrAddr] <= regs[WrAddr] + 1'b1;
                        Carry        <= &regs[WrAddr];
                    end
                    OP_PRESET: regs[WrAddr] <= PresetValue;
                    default:   regs[WrAddr] <= '0;
                endcase
            end
        end
    end

    // Reads see the pre-edge contents; there is deliberately no write bypass.
    for (genvar g = 0; g < NrOfRegs; g++) begin : g_flat
        assign bank_flat[g*NrOfBits +: NrOfBits] = regs[g];
    end

    bank_read_port #(
        .NrOfBits (NrOfBits),
        .NrOfRegs (NrOfRegs),
        .AddrBits (AddrBits)
    ) u_port_a (
        .bank   (bank_flat),
        .RdAddr (RdAddrA),
        .cs     (csA),
        .Q      (QA)
    );

    bank_read_port #(
        .NrOfBits (NrOfBits),
        .NrOfRegs (NrOfRegs),
        .AddrBits (AddrBits)
    ) u_port_b (
        .bank   (bank_flat),
        .RdAddr (RdAddrB),
        .cs     (csB),
        .Q      (QB)
    );

endmodule

// File: tb/tb_multi_register_bank.sv
// tb/tb_multi_register_bank.sv - self-checking bench for multi_register_bank
module tb_multi_register_bank;

    logic       Clock = 1'b0;
    logic       Reset, ClockEnable, Tick, WrEn, csA, csB;
    logic [1:0] WrAddr, RdAddrA, RdAddrB, Op;
    logic [7:0] D;
    logic [7:0] QA, QB;
    logic       Carry, WrAck;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic       we, ce, tk;
        logic [1:0] op, addr;
        logic [7:0] d;
        logic [1:0] ra;
        logic       ca;
        logic [1:0] rb;
        logic       cb;
        logic [7:0] exp_qa, exp_qb;
        logic       exp_ack, exp_carry;
    } vec_t;

    vec_t vecs [12];

    int model [4];
    int m_carry, m_ack;

    always #5 Clock = ~Clock;

    multi_register_bank dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .WrEn(WrEn), .WrAddr(WrAddr), .Op(Op), .D(D),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .csA(csA), .csB(csB),
        .QA(QA), .QB(QB), .Carry(Carry), .WrAck(WrAck)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic ce, input logic tk, input logic [1:0] op,
                         input logic [1:0] addr, input logic [7:0] d);
        WrEn = we; ClockEnable = ce; Tick = tk; Op = op; WrAddr = addr; D = d;
    endtask

    // Reference model: behaviour of one clock edge stated as plain arithmetic.
    task automatic model_edge();
        if (Reset) begin
            for (int i = 0; i < 4; i++) model[i] = 0;
            m_carry = 0;
            m_ack   = 0;
        end else begin
            m_ack = (WrEn && ClockEnable && Tick && (int'(WrAddr) < 4)) ? 1 : 0;
            if (m_ack == 1) begin
                case (Op)
                    2'd0: model[WrAddr] = int'(D);
                    2'd1: begin
                        m_carry = (model[WrAddr] == 255) ? 1 : 0;
                        model[WrAddr] = (model[WrAddr] + 1) % 256;
                    end
                    2'd2: model[WrAddr] = 255;
                    default: model[WrAddr] = 0;
                endcase
            end
        end
    endtask

    function automatic int model_read(input logic [1:0] a, input logic cs);
        return cs ? 0 : model[a];
    endfunction

    initial begin
        //          we  ce  tk  op     addr  d      ra  ca  rb  cb  qa     qb     ack carry
        vecs[0]  = '{1, 1, 1, 2'd0, 2'd1, 8'h5A, 2'd1, 0, 2'd0, 0, 8'h5A, 8'h00, 1, 0};
        vecs[1]  = '{1, 1, 1, 2'd0, 2'd2, 8'hFF, 2'd2, 0, 2'd1, 0, 8'hFF, 8'h5A, 1, 0};
        vecs[2]  = '{1, 1, 1, 2'd1, 2'd2, 8'h00, 2'd2, 0, 2'd2, 0, 8'h00, 8'h00, 1, 1};
        vecs[3]  = '{1, 1, 1, 2'd1, 2'd2, 8'h00, 2'd2, 0, 2'd2, 0, 8'h01, 8'h01, 1, 0};
        vecs[4]  = '{1, 1, 1, 2'd0, 2'd0, 8'hFF, 2'd0, 0, 2'd2, 0, 8'hFF, 8'h01, 1, 0};
        vecs[5]  = '{1, 1, 1, 2'd1, 2'd0, 8'h00, 2'd0, 0, 2'd1, 0, 8'h00, 8'h5A, 1, 1};
        vecs[6]  = '{1, 1, 0, 2'd1, 2'd1, 8'h00, 2'd1, 0, 2'd0, 0, 8'h5A, 8'h00, 0, 1};
        vecs[7]  = '{1, 0, 1, 2'd1, 2'd1, 8'h00, 2'd1, 0, 2'd0, 0, 8'h5A, 8'h00, 0, 1};
        vecs[8]  = '{0, 1, 1, 2'd3, 2'd1, 8'h00, 2'd1, 0, 2'd2, 0, 8'h5A, 8'h01, 0, 1};
        vecs[9]  = '{1, 1, 1, 2'd2, 2'd3, 8'h00, 2'd3, 0, 2'd1, 0, 8'hFF, 8'h5A, 1, 1};
        vecs[10] = '{1, 1, 1, 2'd3, 2'd3, 8'h00, 2'd3, 0, 2'd3, 0, 8'h00, 8'h00, 1, 1};
        vecs[11] = '{0, 1, 1, 2'd0, 2'd0, 8'h00, 2'd1, 1, 2'd1, 0, 8'h00, 8'h5A, 0, 1};

        Reset = 1'b1; csA = 1'b0; csB = 1'b0; RdAddrA = 2'd0; RdAddrB = 2'd0;
        drive(1, 1, 1, 2'd0, 2'd1, 8'h77);
        edge_step();
        edge_step();
        Reset = 1'b0;
        drive(0, 1, 1, 2'd0, 2'd0, 8'h00);
        check("reset_carry", 32'(Carry), 32'd0);
        check("reset_ack", 32'(WrAck), 32'd0);
        for (int i = 0; i < 4; i++) begin
            RdAddrA = 2'(i); RdAddrB = 2'(3 - i);
            #1;
            check("reset_qa", 32'(QA), 32'd0);
            check("reset_qb", 32'(QB), 32'd0);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].ce, vecs[i].tk, vecs[i].op, vecs[i].addr, vecs[i].d);
            RdAddrA = vecs[i].ra; csA = vecs[i].ca; RdAddrB = vecs[i].rb; csB = vecs[i].cb;
            edge_step();
            check($sformatf("vec%0d_qa", i), 32'(QA), 32'(vecs[i].exp_qa));
            check($sformatf("vec%0d_qb", i), 32'(QB), 32'(vecs[i].exp_qb));
            check($sformatf("vec%0d_ack", i), 32'(WrAck), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_carry", i), 32'(Carry), 32'(vecs[i].exp_carry));
        end

        // Read-during-write returns the old value, then the new one after the edge.
        drive(1, 1, 1, 2'd0, 2'd0, 8'h33);
        RdAddrA = 2'd0; csA = 1'b0;
        #1;
        check("rdw_old", 32'(QA), 32'h00);
        edge_step();
        drive(0, 1, 1, 2'd0, 2'd0, 8'h00);
        #1;
        check("rdw_new", 32'(QA), 32'h33);
        csA = 1'b1;
        #1;
        check("rdw_csa_high", 32'(QA), 32'h00);
        csA = 1'b0;

        // Reset overrides a concurrent LOAD; the next LOAD commits normally.
        edge_step();
        Reset = 1'b1;
        drive(1, 1, 1, 2'd0, 2'd1, 8'h77);
        RdAddrA = 2'd1; RdAddrB = 2'd0;
        edge_step();
        check("rst_mid_qa", 32'(QA), 32'h00);
        check("rst_mid_qb", 32'(QB), 32'h00);
        check("rst_mid_ack", 32'(WrAck), 32'd0);
        Reset = 1'b0;
        edge_step();
        check("post_rst_qa", 32'(QA), 32'h77);
        check("post_rst_ack", 32'(WrAck), 32'd1);
        drive(0, 1, 1, 2'd0, 2'd0, 8'h00);
        edge_step();
        check("ack_one_cycle", 32'(WrAck), 32'd0);

        // Randomized run against the reference model.
        Reset = 1'b1;
        model_edge();
        edge_step();
        Reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            Reset = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) D = 8'hFF;
            RdAddrA = 2'($urandom_range(0, 3)); RdAddrB = 2'($urandom_range(0, 3));
            csA = ($urandom_range(0, 4) == 0); csB = ($urandom_range(0, 4) == 0);
            #1;
            check("rnd_pre_qa", 32'(QA), 32'(model_read(RdAddrA, csA)));
            check("rnd_pre_qb", 32'(QB), 32'(model_read(RdAddrB, csB)));
            model_edge();
            edge_step();
            check("rnd_qa", 32'(QA), 32'(model_read(RdAddrA, csA)));
            check("rnd_qb", 32'(QB), 32'(model_read(RdAddrB, csB)));
            check("rnd_ack", 32'(WrAck), 32'(m_ack));
            check("rnd_carry", 32'(Carry), 32'(m_carry));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
